eth_pix_pack: RTL and testbench

ETH_PIX_PACK -- requirements
Module: eth_pix_pack

---
 rtl/eth_pix_pack.sv | 220 ++++++++++++++++++++++
 tb/tb_eth_pix_pack.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pix_pack.sv
// rtl/eth_pix_pack.sv - RGB565 line capture into ping-pong banks, streamed out as UDP payloads
// Sync packets mark pix_vs edges; line packets carry a serial followed by RGB888 bytes.
module eth_pix_pack #(
  parameter int H_ACT = 640
) (
  input  logic        rgmii_txc,
  input  logic        rst,
  input  logic        pix_vs,
  input  logic        pix_de,
  input  logic [15:0] pix_data,
  output logic        udp_tx_start,
  input  logic        udp_tx_ready,
  output logic [15:0] udp_send_data_length,
  input  logic        udp_tx_req,
  output logic [7:0]  udp_send_data,
  output logic        line_ovf,
  output logic [15:0] drop_cnt,
  output logic        busy
);
  localparam int AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int CW = $clog2(H_ACT + 2);
  localparam logic [15:0] LINE_LEN = 16'(2 + 3 * H_ACT);
  localparam logic [63:0] VS_RISE  = 64'h5673_5F52_6973_6521;
  localparam logic [63:0] VS_FALL  = 64'h5673_5F46_616C_6C21;

  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;
  state_t state;

  logic [15:0]   mem [2][H_ACT];
  logic [15:0]   rd_q, pix_hold;
  logic [AW-1:0] rd_addr;
  logic          vs_d, de_d;
  logic [1:0]    full;
  logic          oldest;
  logic [15:0]   serial [2];
  logic [15:0]   line_idx;
  logic          cap_active, wr_bank;
  logic [CW-1:0] cnt;
  logic          rise_pend, fall_pend, fall_first;
  logic          tx_sync, tx_fall, tx_bank;
  logic [15:0]   byte_cnt;
  logic [1:0]    phase;

  logic          line_start, line_end, vs_rise, vs_fall, free_any, free_sel;
  logic          wr_en, wr_sel, mark, rel, clr_rise, clr_fall;
  logic [AW-1:0] wr_addr;

  function automatic logic [7:0] sync_byte(input logic fall, input logic [2:0] idx);
    logic [63:0] s;
    s = fall ? VS_FALL : VS_RISE;
    return s[8*(7 - int'(idx)) +: 8];
  endfunction

  function automatic logic [7:0] exp_r(input logic [15:0] p);
    return {p[15:11], p[15:13]};
  endfunction

  function automatic logic [7:0] exp_g(input logic [15:0] p);
    return {p[10:5], p[10:9]};
  endfunction

  function automatic logic [7:0] exp_b(input logic [15:0] p);
    return {p[4:0], p[4:2]};
  endfunction

  assign line_start = pix_de & ~de_d;
  assign line_end   = ~pix_de & de_d;
  assign vs_rise    = pix_vs & ~vs_d;
  assign vs_fall    = ~pix_vs & vs_d;
  assign free_any   = ~full[0] | ~full[1];
  assign free_sel   = full[0];
  // The first pixel of a line lands in the same cycle the bank is chosen.
  assign wr_en      = pix_de & (line_start ? free_any : (cap_active & (cnt < CW'(H_ACT))));
  assign wr_sel     = line_start ? free_sel : wr_bank;
  assign wr_addr    = line_start ? '0 : AW'(cnt);
  assign mark       = line_end & cap_active & (cnt == CW'(H_ACT));
  assign rel        = (state == DONE) & ~tx_sync;
  assign clr_rise   = (state == DONE) & tx_sync & ~tx_fall;
  assign clr_fall   = (state == DONE) & tx_sync & tx_fall;
  assign busy       = (state != IDLE);

  always_ff @(posedge rgmii_txc) begin
    if (wr_en) mem[wr_sel][wr_addr] <= pix_data;
    rd_q <= mem[tx_bank][rd_addr];
  end

  always_ff @(posedge rgmii_txc or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      vs_d                 <= 1'b0;
      de_d                 <= 1'b0;
      full                 <= 2'b00;
      oldest               <= 1'b0;
      serial[0]            <= '0;
      serial[1]            <= '0;
      line_idx             <= '0;
      cap_active           <= 1'b0;
      wr_bank              <= 1'b0;
      cnt                  <= '0;
      rise_pend            <= 1'b0;
      fall_pend            <= 1'b0;
      fall_first           <= 1'b0;
      tx_sync              <= 1'b0;
      tx_fall              <= 1'b0;
      tx_bank              <= 1'b0;
      byte_cnt             <= '0;
      phase                <= '0;
      rd_addr              <= '0;
      pix_hold             <= '0;
      udp_tx_start         <= 1'b0;
      udp_send_data        <= 8'h00;
      udp_send_data_length <= '0;
      line_ovf             <= 1'b0;
      drop_cnt             <= '0;
    end else begin
      vs_d <= pix_vs;
      de_d <= pix_de;

      if (line_start) begin
        cap_active <= free_any;
        wr_bank    <= free_sel;
        cnt        <= CW'(1);
      end else if (pix_de && cnt <= CW'(H_ACT)) begin
        cnt <= cnt + CW'(1);
      end

      if (line_end) begin
        if (mark) begin
          serial[wr_bank] <= line_idx;
        end else begin
          line_ovf <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end

      if (vs_rise) line_idx <= '0;
      else if (line_end) line_idx <= line_idx + 16'd1;

      // Release and fill may hit different banks in the same cycle.
      if (rel) full[tx_bank] <= 1'b0;
      if (mark) full[wr_bank] <= 1'b1;
      if (mark) begin
        if (!full[~wr_bank] || rel) oldest <= wr_bank;
      end else if (rel) begin
        oldest <= ~tx_bank;
      end

      if (clr_rise) rise_pend <= 1'b0;
      if (clr_fall) fall_pend <= 1'b0;
      if (vs_rise) begin
        rise_pend  <= 1'b1;
        fall_first <= fall_pend & ~clr_fall;
      end
      if (vs_fall) begin
        fall_pend  <= 1'b1;
        fall_first <= ~(rise_pend & ~clr_rise);
      end

      udp_send_data <= 8'h00;
      case (state)
        IDLE: begin
          rd_addr  <= '0;
          byte_cnt <= '0;
          phase    <= '0;
          if (rise_pend || fall_pend) begin
            tx_sync              <= 1'b1;
            tx_fall              <= (rise_pend & fall_pend) ? fall_first : fall_pend;
            udp_send_data_length <= 16'd8;
            udp_tx_start         <= 1'b1;
            state                <= REQ;
          end else if (full[oldest]) begin
            tx_sync              <= 1'b0;
            tx_bank              <= oldest;
            udp_send_data_length <= LINE_LEN;
            udp_tx_start         <= 1'b1;
            state                <= REQ;
          end
        end
        REQ: begin
          if (udp_tx_ready) begin
            udp_tx_start <= 1'b0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (udp_tx_req && byte_cnt < udp_send_data_length) begin
            if (tx_sync) begin
              udp_send_data <= sync_byte(tx_fall, byte_cnt[2:0]);
            end else if (byte_cnt == 16'd0) begin
              udp_send_data <= serial[tx_bank][15:8];
            end else if (byte_cnt == 16'd1) begin
              udp_send_data <= serial[tx_bank][7:0];
            end else begin
              // rd_q is refetched for the next pixel while G and B go out.
              case (phase)
                2'd0: begin
                  udp_send_data <= exp_r(rd_q);
                  pix_hold      <= rd_q;
                  if (rd_addr != AW'(H_ACT - 1)) rd_addr <= rd_addr + AW'(1);
                  phase <= 2'd1;
                end
                2'd1: begin
                  udp_send_data <= exp_g(pix_hold);
                  phase         <= 2'd2;
                end
                default: begin
                  udp_send_data <= exp_b(pix_hold);
                  phase         <= 2'd0;
                end
              endcase
            end
            byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt == udp_send_data_length - 16'd1) state <= DONE;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_pix_pack.sv
// tb/tb_eth_pix_pack.sv - scoreboard bench for eth_pix_pack
module tb_eth_pix_pack;
  localparam int H = 640;
  localparam logic [15:0] LLEN = 16'd1922;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_vs = 1'b0;
  logic        pix_de = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        udp_tx_ready = 1'b0;
  logic        udp_tx_req = 1'b0;
  logic        udp_tx_start;
  logic [15:0] udp_send_data_length;
  logic [7:0]  udp_send_data;
  logic        line_ovf;
  logic [15:0] drop_cnt;
  logic        busy;

  eth_pix_pack dut (
    .rgmii_txc(clk), .rst(rst), .pix_vs(pix_vs), .pix_de(pix_de), .pix_data(pix_data),
    .udp_tx_start(udp_tx_start), .udp_tx_ready(udp_tx_ready),
    .udp_send_data_length(udp_send_data_length), .udp_tx_req(udp_tx_req),
    .udp_send_data(udp_send_data), .line_ovf(line_ovf), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_len[$];
  bit ready_en = 0, rand_req = 0, extra_req = 0, req_live = 0, stack_active = 0, aborted = 0;
  int abort_at = 0;
  int sent = 0;
  bit pend = 0, pend_zero = 0;

  logic [7:0]  rise_b [8] = '{8'h56, 8'h73, 8'h5F, 8'h52, 8'h69, 8'h73, 8'h65, 8'h21};
  logic [7:0]  fall_b [8] = '{8'h56, 8'h73, 8'h5F, 8'h46, 8'h61, 8'h6C, 8'h6C, 8'h21};
  logic [15:0] pat_pix [4] = '{16'h4A69, 16'h07E0, 16'h001F, 16'h8410};
  logic [23:0] pat_rgb [4] = '{24'h4A4D4A, 24'h00FF00, 24'h0000FF, 24'h848284};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_sync(input bit fall);
    exp_len.push_back(16'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back(fall ? fall_b[i] : rise_b[i]);
  endtask

  task automatic push_line(input logic [15:0] ser, input int kind);
    logic [23:0] rgb;
    exp_len.push_back(LLEN);
    exp_q.push_back(ser[15:8]);
    exp_q.push_back(ser[7:0]);
    for (int i = 0; i < H; i++) begin
      rgb = (kind != 0) ? pat_rgb[i % 4] : 24'hFF0000;
      exp_q.push_back(rgb[23:16]);
      exp_q.push_back(rgb[15:8]);
      exp_q.push_back(rgb[7:0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      pix_de   = 1'b1;
      pix_data = (kind != 0) ? pat_pix[i % 4] : 16'hF800;
      cyc(1);
    end
    pix_de   = 1'b0;
    pix_data = 16'h0000;
    cyc(1);
  endtask

  task automatic vs_pulse();
    pix_vs = 1'b1;
    cyc(4);
    pix_vs = 1'b0;
    cyc(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 16'(udp_tx_start), 16'h0);
    check({tag, "_data"}, 16'(udp_send_data), 16'h0);
    check({tag, "_length"}, udp_send_data_length, 16'h0);
    check({tag, "_ovf"}, 16'(line_ovf), 16'h0);
    check({tag, "_drop"}, drop_cnt, 16'h0);
    check({tag, "_busy"}, 16'(busy), 16'h0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (exp_len.size() == 0 && exp_q.size() == 0 && !busy && !stack_active) break;
    end
    check("drain_left", 16'(exp_q.size() + exp_len.size()), 16'h0);
    check("drain_busy", 16'(busy), 16'h0);
    @(posedge clk);
    #1;
  endtask

  // UDP stack model: grants requests and pulls bytes
  initial begin : stack
    int n;
    forever begin
      @(negedge clk);
      if (udp_tx_start && ready_en && !rst) begin
        stack_active = 1;
        if (exp_len.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_packet: got length %0d, required no packet", udp_send_data_length);
        end else begin
          check("length", udp_send_data_length, exp_len.pop_front());
        end
        n = int'(udp_send_data_length);
        if (n > 2000) n = 2000;
        @(posedge clk);
        #1 udp_tx_ready = 1'b1;
        @(posedge clk);
        #1 udp_tx_ready = 1'b0;
        sent = 0;
        while (sent < n) begin
          if (abort_at > 0 && n == int'(LLEN) && sent == abort_at) begin
            rst = 1'b1;
            udp_tx_req = 1'b0;
            req_live = 0;
            aborted = 1;
            break;
          end
          if (!rand_req || $urandom_range(0, 1) == 1) begin
            udp_tx_req = 1'b1;
            req_live = 1;
            sent++;
          end else begin
            udp_tx_req = 1'b0;
            req_live = 0;
          end
          @(posedge clk);
          #1;
        end
        udp_tx_req = 1'b0;
        req_live = 0;
        if (extra_req && !aborted) begin
          udp_tx_req = 1'b1;
          @(posedge clk);
          #1 udp_tx_req = 1'b0;
        end
        stack_active = 0;
      end
    end
  end

  // Monitor: byte is due the cycle after each live request
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      pend_zero = 0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL byte_unexpected: got %h, required none", udp_send_data);
        end else begin
          check("byte", 16'(udp_send_data), 16'(exp_q.pop_front()));
        end
      end
      if (pend_zero) check("extra_req_data", 16'(udp_send_data), 16'h0);
      pend = udp_tx_req && req_live;
      pend_zero = udp_tx_req && !req_live;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(2);

    // Sync packets only
    ready_en = 1;
    push_sync(0);
    push_sync(1);
    vs_pulse();
    wait_done();

    // One solid red line after a frame sync
    push_sync(0);
    push_sync(1);
    vs_pulse();
    push_line(16'h0000, 0);
    drive_line(H, 0);
    wait_done();

    // Short line dropped, next line keeps counting
    do_reset();
    push_sync(0);
    push_sync(1);
    vs_pulse();
    drive_line(H - 1, 1);
    cyc(3);
    @(negedge clk);
    check("short_drop", drop_cnt, 16'd1);
    check("short_ovf", 16'(line_ovf), 16'h1);
    @(posedge clk);
    #1;
    push_line(16'h0001, 1);
    drive_line(H, 1);
    wait_done();
    check("short_drop_after", drop_cnt, 16'd1);

    // Three lines with the stack stalled: third line has no bank
    do_reset();
    ready_en = 0;
    push_sync(0);
    push_sync(1);
    vs_pulse();
    push_line(16'h0000, 1);
    push_line(16'h0001, 0);
    drive_line(H, 1);
    drive_line(H, 0);
    drive_line(H, 1);
    cyc(3);
    @(negedge clk);
    check("full_drop", drop_cnt, 16'd1);
    check("full_ovf", 16'(line_ovf), 16'h1);
    check("stall_start", 16'(udp_tx_start), 16'h1);
    check("stall_busy", 16'(busy), 16'h1);
    check("stall_length", udp_send_data_length, 16'd8);
    @(posedge clk);
    #1;
    rand_req = 1;
    extra_req = 1;
    ready_en = 1;
    wait_done();
    cyc(5);
    @(negedge clk);
    check("extra_busy", 16'(busy), 16'h0);
    check("extra_start", 16'(udp_tx_start), 16'h0);
    @(posedge clk);
    #1;
    rand_req = 0;
    extra_req = 0;

    // Reset in the middle of a line packet
    do_reset();
    abort_at = 100;
    push_sync(0);
    push_sync(1);
    vs_pulse();
    push_line(16'h0000, 1);
    drive_line(H, 1);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (aborted) break;
    end
    check("abort_seen", 16'(aborted), 16'h1);
    check_reset_vals("abort");
    exp_q.delete();
    exp_len.delete();
    abort_at = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    aborted = 0;
    cyc(2);
    push_sync(0);
    push_sync(1);
    vs_pulse();
    wait_done();
    cyc(200);
    @(negedge clk);
    check("post_abort_idle", 16'(busy), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
